// File: rtl/div_seq.sv
// Purpose : iterative RV32M DIV/DIVU/REM/REMU sequencer borrowing the core ALU in subtract mode.
// Latency : done in cycle 37 after start is accepted (cycle 1 for div0/ovf when DIV_EARLY_OUT_EN is defined).
// Backpressure: start is only sampled when idle (busy=0); kill aborts at any time and returns to IDLE.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             alu_sel,
    output logic [3:0]       alu_ctr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_less
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS_A,
        S_ABS_B,
        S_ITER,
        S_FIX_Q,
        S_FIX_R,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

    state_t           state;
    state_t           state_nxt;

    // Operand A becomes the quotient as it shifts out through ITER.
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] orig_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] hold_a;
    logic [WIDTH-1:0] hold_b;
    logic [4:0]       cnt;
    logic             is_rem;
    logic             sgn;
    logic             neg_q;
    logic             neg_r;
    logic             div0;
    logic             ovf;

    logic             accept;
    logic             in_div0;
    logic             in_ovf;
    logic             in_sgn;
    logic [WIDTH-1:0] iter_s;
    logic             iter_h;
    logic             iter_take;
    logic             load_res;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] drv_a;
    logic [WIDTH-1:0] drv_b;

    // Selects quotient or remainder, with the RISC-V div0 and overflow results overriding.
    function automatic logic [WIDTH-1:0] pick_result(
        input logic             f_rem,
        input logic             f_div0,
        input logic             f_ovf,
        input logic [WIDTH-1:0] f_q,
        input logic [WIDTH-1:0] f_r,
        input logic [WIDTH-1:0] f_a
    );
        logic [WIDTH-1:0] v;
        if (f_div0) begin
            v = f_rem ? f_a : ALL_ONE;
        end else if (f_ovf) begin
            v = f_rem ? '0 : MIN_NEG;
        end else begin
            v = f_rem ? f_r : f_q;
        end
        return v;
    endfunction

    assign accept    = (state == S_IDLE) && start && !kill;
    assign in_sgn    = ~op[0];
    assign in_div0   = (divisor == '0);
    assign in_ovf    = in_sgn && (dividend == MIN_NEG) && (divisor == ALL_ONE);

    // Shifted partial remainder; the bit shifted out (h) marks a value beyond WIDTH bits,
    // in which case the subtraction always fits and the wrapped difference is exact.
    assign iter_s    = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign iter_h    = rem_q[WIDTH-1];
    assign iter_take = iter_h | ~alu_less;

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign result    = res_q;
    assign alu_ctr   = 4'b1000;
    assign alu_a     = drv_a;
    assign alu_b     = drv_b;

    // Next-state, ALU operand mux and result-load decision.
    always_comb begin
        state_nxt = state;
        alu_sel   = 1'b0;
        drv_a     = hold_a;
        drv_b     = hold_b;
        load_res  = 1'b0;
        res_nxt   = res_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef DIV_EARLY_OUT_EN
                    if (in_div0 || in_ovf) begin
                        state_nxt = S_DONE;
                        load_res  = 1'b1;
                        res_nxt   = pick_result(op[1], in_div0, in_ovf, '0, '0, dividend);
                    end else begin
                        state_nxt = S_ABS_A;
                    end
`else
                    state_nxt = S_ABS_A;
`endif
                end
            end
            S_ABS_A: begin
                alu_sel   = 1'b1;
                drv_a     = '0;
                drv_b     = quo_q;
                state_nxt = S_ABS_B;
            end
            S_ABS_B: begin
                alu_sel   = 1'b1;
                drv_a     = '0;
                drv_b     = dvs_q;
                state_nxt = S_ITER;
            end
            S_ITER: begin
                alu_sel = 1'b1;
                drv_a   = iter_s;
                drv_b   = dvs_q;
                if (&cnt) begin
                    state_nxt = S_FIX_Q;
                end
            end
            S_FIX_Q: begin
                alu_sel   = 1'b1;
                drv_a     = '0;
                drv_b     = quo_q;
                state_nxt = S_FIX_R;
            end
            S_FIX_R: begin
                alu_sel   = 1'b1;
                drv_a     = '0;
                drv_b     = rem_q;
                state_nxt = S_DONE;
                load_res  = !kill;
                res_nxt   = pick_result(is_rem, div0, ovf, quo_q,
                                        neg_r ? alu_out : rem_q, orig_q);
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (kill) begin
            state_nxt = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, sign conversion, restoring iterations and sign fix-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
            orig_q <= '0;
            cnt    <= '0;
            is_rem <= 1'b0;
            sgn    <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        quo_q  <= dividend;
                        dvs_q  <= divisor;
                        orig_q <= dividend;
                        rem_q  <= '0;
                        cnt    <= '0;
                        is_rem <= op[1];
                        sgn    <= in_sgn;
                        neg_q  <= in_sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]) && !in_div0;
                        neg_r  <= in_sgn && dividend[WIDTH-1];
                        div0   <= in_div0;
                        ovf    <= in_ovf;
                    end
                end
                S_ABS_A: begin
                    if (sgn && quo_q[WIDTH-1]) begin
                        quo_q <= alu_out;
                    end
                end
                S_ABS_B: begin
                    if (sgn && dvs_q[WIDTH-1]) begin
                        dvs_q <= alu_out;
                    end
                end
                S_ITER: begin
                    rem_q <= iter_take ? alu_out : iter_s;
                    quo_q <= {quo_q[WIDTH-2:0], iter_take};
                    cnt   <= cnt + 5'd1;
                end
                S_FIX_Q: begin
                    if (neg_q) begin
                        quo_q <= alu_out;
                    end
                end
                S_FIX_R: begin
                    if (neg_r) begin
                        rem_q <= alu_out;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ALU operands hold their last driven values while the ALU is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_a <= '0;
            hold_b <= '0;
        end else if (alu_sel) begin
            hold_a <= drv_a;
            hold_b <= drv_b;
        end
    end

    // Result register: written only on a completed (not killed) operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= '0;
        end else if (load_res) begin
            res_q <= res_nxt;
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Purpose : self-checking bench for div_seq with a combinational subtract ALU and a reference divider.
// Latency : each operation is tracked cycle by cycle from acceptance through the first IDLE cycle.
// Backpressure: new requests are only issued while the DUT is idle, including back-to-back after done.
module tb_div_seq;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        alu_sel;
    logic [3:0]  alu_ctr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;
    logic        alu_less;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_res = 32'h0;

    div_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .kill     (kill),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .alu_sel  (alu_sel),
        .alu_ctr  (alu_ctr),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_out  (alu_out),
        .alu_less (alu_less)
    );

    // Core ALU in subtract / unsigned-compare mode.
    assign alu_out  = alu_a - alu_b;
    assign alu_less = (alu_a < alu_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // RISC-V M-extension semantics straight from the ISA rules.
    function automatic logic [31:0] model(input logic [1:0] mop, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!mop[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else if (!mop[0]) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return mop[1] ? r : q;
    endfunction

    // Issues one operation at the current negedge and checks every cycle through the first
    // IDLE cycle; returns at that cycle's negedge so a following call is back-to-back.
    task automatic run_op(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                          input bit use_lit, input logic [31:0] lit);
        logic [31:0] exp;
        bit          special;
        int          lat;
        exp     = use_lit ? lit : model(mop, a, b);
        special = (b == 32'h0) || (!mop[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        lat     = (EARLY && special) ? 1 : 37;
        start    = 1'b1;
        op       = mop;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= lat + 1; cyc++) begin
            @(negedge clk);
            chk("done", 32'(done), 32'(cyc == lat));
            chk("busy", 32'(busy), 32'(cyc <= lat));
            chk("alu_sel", 32'(alu_sel), 32'((lat == 37) && (cyc <= 36)));
            chk("alu_ctr", 32'(alu_ctr), 32'h8);
            if (cyc == 1 && lat == 37) begin
                chk("abs_a_opa", alu_a, 32'h0);
                chk("abs_a_opb", alu_b, a);
            end
            if (cyc == lat) begin
                chk($sformatf("result op=%0d a=%h b=%h", mop, a, b), result, exp);
            end
            if (cyc == lat + 1) begin
                chk("result_hold", result, exp);
            end
        end
        last_res = exp;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        dividend = 32'h0;
        divisor  = 32'h0;
        kill     = 1'b0;
        #3;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_alu_sel", 32'(alu_sel), 32'h0);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        chk("rst_alu_ctr", 32'(alu_ctr), 32'h8);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Hand-computed expectations.
        run_op(2'b01, 32'd100, 32'd7, 1'b1, 32'd14);
        run_op(2'b11, 32'd100, 32'd7, 1'b1, 32'd2);
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1);
        run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 32'd1);
        run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 32'h7FFF_FFFE);
        run_op(2'b00, 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF);
        run_op(2'b10, 32'd5, 32'd0, 1'b1, 32'd5);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0);
        run_op(2'b01, 32'd9, 32'd0, 1'b1, 32'hFFFF_FFFF);
        run_op(2'b11, 32'd9, 32'd0, 1'b1, 32'd9);

        // Kill in ITER cycle 10 (cycle 13 after acceptance).
        start    = 1'b1;
        op       = 2'b01;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 13; cyc++) begin
            @(negedge clk);
            chk("kill_nodone", 32'(done), 32'h0);
        end
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        chk("kill_busy", 32'(busy), 32'h0);
        chk("kill_done", 32'(done), 32'h0);
        chk("kill_result", result, last_res);
        run_op(2'b00, 32'd1000, 32'hFFFF_FFFD, 1'b0, 32'h0);

        // Asynchronous reset in cycle 20, checked before any clock edge.
        start    = 1'b1;
        op       = 2'b11;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'd77;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        chk("arst_result", result, 32'h0);
        chk("arst_alu_sel", 32'(alu_sel), 32'h0);
        chk("arst_alu_a", alu_a, 32'h0);
        chk("arst_alu_b", alu_b, 32'h0);
        #1 rst = 1'b0;
        last_res = 32'h0;
        @(negedge clk);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic [1:0]  rop;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 20));
                3:       rb = {1'b1, 31'($urandom)};
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) begin
                ra = 32'h8000_0000;
            end
            run_op(rop, ra, rb, 1'b0, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
